// File: rtl/psum_pool_collect_if.sv
// Stream bundle between the mesh partial-sum source, the window collector and the write-back side.
// The slave modport is the collector's view of the bundle.
interface psum_pool_collect_if #(
   parameter int X_MESH      = 16,
   parameter int COM_DATALEN = 24
);
   logic                              in_valid;
   logic                              in_ready;
   logic [2*COM_DATALEN*X_MESH-1:0]   in_data;
   logic [4*COM_DATALEN*X_MESH-1:0]   out_data_4;
   logic [COM_DATALEN*X_MESH-1:0]     out_data_1;
   logic                              dvalid;

   modport master (
      output in_valid, in_data,
      input  in_ready, out_data_4, out_data_1, dvalid
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, out_data_4, out_data_1, dvalid
   );
endinterface

// File: rtl/psum_pool_collect.sv
// Assembles 2x2 windows from a row-pair stream of mesh partial sums.
// Each window is emitted raw and 2x2 max-pooled. The top row of a pair is parked in a line buffer.
module psum_pool_collect #(
   parameter int X_MESH       = 16,
   parameter int COM_DATALEN  = 24,
   parameter int MAX_LINE_LEN = 10,
   parameter int ROW_LEN      = 10,
   parameter int LB_DEPTH     = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    conf,
   input  logic [MAX_LINE_LEN-1:0] pairs_per_row,
   input  logic [ROW_LEN-1:0]      row_pairs,
   psum_pool_collect_if.slave      bus,
   output logic                    busy,
   output logic                    done
);
   localparam int W   = COM_DATALEN;
   localparam int IW  = 2*W*X_MESH;
   localparam int OW4 = 4*W*X_MESH;
   localparam int OW1 = W*X_MESH;
   localparam int AW  = $clog2(LB_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_TOP, ST_BOT, ST_DONE} state_t;

   state_t                  state_q, state_d;
   logic [MAX_LINE_LEN-1:0] col_q, col_d, ppr_q, ppr_d;
   logic [ROW_LEN-1:0]      row_q, row_d, nrows_q, nrows_d, rowInc;
   logic                    dvalid_q, dvalid_d;
   logic [OW4-1:0]          out4_q, out4_d;
   logic [OW1-1:0]          out1_q, out1_d;
   logic                    inReady, accept, lastCol, lbWe;
   logic [IW-1:0]           lb [LB_DEPTH];
   logic [IW-1:0]           lbRd;
   logic [OW4-1:0]          win4;
   logic [OW1-1:0]          win1;

   assign inReady = (state_q == ST_TOP) || (state_q == ST_BOT);
   assign accept  = inReady && bus.in_valid;
   assign lastCol = (col_q == ppr_q - MAX_LINE_LEN'(1));
   assign rowInc  = row_q + ROW_LEN'(1);
   assign lbRd    = lb[col_q[AW-1:0]];

   // Per lane: row 0 comes from the line buffer, row 1 from the live beat.
   for (genvar g = 0; g < X_MESH; g++) begin : gLane
      logic signed [W-1:0] p00, p01, p10, p11, m0, m1;
      assign p00 = lbRd[(2*g)*W +: W];
      assign p01 = lbRd[(2*g+1)*W +: W];
      assign p10 = bus.in_data[(2*g)*W +: W];
      assign p11 = bus.in_data[(2*g+1)*W +: W];
      assign m0  = (p00 > p01) ? p00 : p01;
      assign m1  = (p10 > p11) ? p10 : p11;
      assign win1[g*W +: W]         = (m0 > m1) ? m0 : m1;
      assign win4[(4*g)*W +: 4*W]   = {p11, p10, p01, p00};
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      ppr_d    = ppr_q;
      nrows_d  = nrows_q;
      dvalid_d = 1'b0;
      out4_d   = out4_q;
      out1_d   = out1_q;
      lbWe     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (conf) begin
               ppr_d   = pairs_per_row;
               nrows_d = row_pairs;
               col_d   = '0;
               row_d   = '0;
               state_d = (pairs_per_row == '0 || row_pairs == '0) ? ST_DONE : ST_TOP;
            end
         end
         ST_TOP: begin
            if (accept) begin
               lbWe = 1'b1;
               if (lastCol) begin
                  col_d   = '0;
                  state_d = ST_BOT;
               end else begin
                  col_d = col_q + MAX_LINE_LEN'(1);
               end
            end
         end
         ST_BOT: begin
            if (accept) begin
               dvalid_d = 1'b1;
               out4_d   = win4;
               out1_d   = win1;
               if (lastCol) begin
                  col_d   = '0;
                  row_d   = rowInc;
                  state_d = (rowInc == nrows_q) ? ST_DONE : ST_TOP;
               end else begin
                  col_d = col_q + MAX_LINE_LEN'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         col_q    <= '0;
         row_q    <= '0;
         ppr_q    <= '0;
         nrows_q  <= '0;
         dvalid_q <= 1'b0;
         out4_q   <= '0;
         out1_q   <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         ppr_q    <= ppr_d;
         nrows_q  <= nrows_d;
         dvalid_q <= dvalid_d;
         out4_q   <= out4_d;
         out1_q   <= out1_d;
      end
   end

   // Line buffer is deliberately left out of reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (lbWe) lb[col_q[AW-1:0]] <= bus.in_data;
   end

   assign bus.in_ready   = inReady;
   assign bus.dvalid     = dvalid_q;
   assign bus.out_data_4 = out4_q;
   assign bus.out_data_1 = out1_q;
   assign busy           = inReady;
   assign done           = (state_q == ST_DONE);
endmodule

// File: tb/tb_psum_pool_collect.sv
// Randomized bench for psum_pool_collect: a queue-based window model predicts every dvalid beat,
// plus directed windows for signed pooling, empty jobs, ignored conf and mid-job reset.
module tb_psum_pool_collect;
   localparam int X   = 16;
   localparam int W   = 24;
   localparam int IW  = 2*W*X;
   localparam int OW4 = 4*W*X;
   localparam int OW1 = W*X;
   localparam int LBD = 512;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       conf;
   logic [9:0] pairsPerRow;
   logic [9:0] rowPairs;
   logic       busy;
   logic       done;

   psum_pool_collect_if #(.X_MESH(X), .COM_DATALEN(W)) bus ();

   psum_pool_collect #(
      .X_MESH(X), .COM_DATALEN(W), .MAX_LINE_LEN(10), .ROW_LEN(10), .LB_DEPTH(LBD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .conf(conf), .pairs_per_row(pairsPerRow),
      .row_pairs(rowPairs), .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef logic [IW-1:0] beat_t;
   typedef struct {
      logic [OW4-1:0] raw;
      logic [OW1-1:0] pooled;
   } win_t;

   int    vecCount = 0;
   int    errCount = 0;
   beat_t planQ[$];
   win_t  expQ[$];

   task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vecCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic beat_t randBeat();
      beat_t b;
      for (int j = 0; j < IW/32; j++) b[j*32 +: 32] = $urandom;
      return b;
   endfunction

   function automatic beat_t lane0Beat(input int p0, input int p1);
      beat_t b = '0;
      b[0 +: W] = W'(p0);
      b[W +: W] = W'(p1);
      return b;
   endfunction

   function automatic logic signed [W-1:0] pix(input beat_t b, input int lane, input int k);
      return b[(2*lane+k)*W +: W];
   endfunction

   // Reference: row pair r holds ppr top beats followed by ppr bottom beats in planQ.
   task automatic buildExpected(input int ppr, input int nrows);
      win_t w;
      beat_t t, b;
      logic signed [W-1:0] v[4];
      logic signed [W-1:0] m;
      expQ.delete();
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < ppr; c++) begin
            t = planQ[r*2*ppr + c];
            b = planQ[r*2*ppr + ppr + c];
            for (int i = 0; i < X; i++) begin
               v[0] = pix(t, i, 0); v[1] = pix(t, i, 1);
               v[2] = pix(b, i, 0); v[3] = pix(b, i, 1);
               m = v[0];
               for (int k = 0; k < 4; k++) begin
                  w.raw[(4*i+k)*W +: W] = v[k];
                  if (v[k] > m) m = v[k];
               end
               w.pooled[i*W +: W] = m;
            end
            expQ.push_back(w);
         end
      end
   endtask

   task automatic planRandom(input int ppr, input int nrows);
      planQ.delete();
      for (int n = 0; n < 2*ppr*nrows; n++) planQ.push_back(randBeat());
   endtask

   // Runs one job from planQ; sampling and driving both happen at the falling edge.
   task automatic applyStimulus(input int ppr, input int nrows, input int validPct,
                                input bit confNoise, input int abortAt);
      int  cyc, dv, budget;
      bit  doneSeen;
      win_t w;
      buildExpected(ppr, nrows);
      budget = (2*ppr*nrows + 10) * 400 / validPct;
      @(negedge clk);
      conf = 1'b1; pairsPerRow = 10'(ppr); rowPairs = 10'(nrows); bus.in_valid = 1'b0;
      @(negedge clk);
      conf = 1'b0;
      cyc = 0; dv = 0; doneSeen = 1'b0;
      while (!doneSeen && cyc < budget) begin
         checkOutput("in_ready vs busy", 96'(bus.in_ready), 96'(busy));
         if (bus.dvalid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected dvalid", 96'd1, 96'd0);
            end else begin
               w = expQ.pop_front();
               for (int i = 0; i < X; i++) begin
                  checkOutput($sformatf("raw4 win%0d lane%0d", dv, i),
                              bus.out_data_4[i*96 +: 96], w.raw[i*96 +: 96]);
                  checkOutput($sformatf("pool win%0d lane%0d", dv, i),
                              96'(bus.out_data_1[i*W +: W]), 96'(w.pooled[i*W +: W]));
               end
            end
            dv++;
         end
         if (done) begin
            doneSeen = 1'b1;
            checkOutput("dvalid with done", 96'(bus.dvalid), 96'(ppr*nrows != 0));
            checkOutput("dvalid count", 96'(dv), 96'(ppr*nrows));
            checkOutput("beats left", 96'(planQ.size()), 96'd0);
            if (ppr*nrows == 0) checkOutput("empty job done latency", 96'(cyc), 96'd0);
         end
         if (abortAt > 0 && dv == abortAt) begin
            #2 rst_n = 1'b0;
            #1;
            checkOutput("reset dvalid", 96'(bus.dvalid), 96'd0);
            checkOutput("reset done", 96'(done), 96'd0);
            checkOutput("reset busy", 96'(busy), 96'd0);
            checkOutput("reset in_ready", 96'(bus.in_ready), 96'd0);
            checkOutput("reset out_data_1", 96'(bus.out_data_1[0 +: W]), 96'd0);
            bus.in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            planQ.delete();
            expQ.delete();
            return;
         end
         conf = 1'b0;
         bus.in_valid = 1'b0;
         if (!doneSeen) begin
            if (confNoise && busy && $urandom_range(0, 9) == 0) begin
               conf = 1'b1;
               pairsPerRow = 10'($urandom_range(1, 7));
               rowPairs = 10'($urandom_range(1, 7));
            end
            if (planQ.size() > 0 && $urandom_range(1, 100) <= validPct) begin
               bus.in_valid = 1'b1;
               bus.in_data  = planQ[0];
               if (bus.in_ready) void'(planQ.pop_front());
            end else begin
               bus.in_data = randBeat();
            end
            @(negedge clk);
         end
         cyc++;
      end
      if (!doneSeen) checkOutput("done timeout", 96'd0, 96'd1);
      planQ.delete();
   endtask

   initial begin
      rst_n = 1'b0; conf = 1'b0; pairsPerRow = '0; rowPairs = '0;
      bus.in_valid = 1'b0; bus.in_data = '0;
      #1;
      checkOutput("rst dvalid", 96'(bus.dvalid), 96'd0);
      checkOutput("rst done", 96'(done), 96'd0);
      checkOutput("rst busy", 96'(busy), 96'd0);
      checkOutput("rst in_ready", 96'(bus.in_ready), 96'd0);
      checkOutput("rst out_data_4 lane0", bus.out_data_4[0 +: 96], 96'd0);
      checkOutput("rst out_data_1 lane0", 96'(bus.out_data_1[0 +: W]), 96'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      planQ.delete();
      planQ.push_back(lane0Beat(1, 2)); planQ.push_back(lane0Beat(3, 4));
      planQ.push_back(lane0Beat(5, 6)); planQ.push_back(lane0Beat(7, 8));
      applyStimulus(2, 1, 100, 1'b0, 0);
      checkOutput("basic last raw lane0", bus.out_data_4[0 +: 96], {24'd8, 24'd7, 24'd4, 24'd3});
      checkOutput("basic last pool lane0", 96'(bus.out_data_1[0 +: W]), 96'd8);

      planQ.delete();
      planQ.push_back(lane0Beat(-5, -3)); planQ.push_back(lane0Beat(-128, -7));
      applyStimulus(1, 1, 100, 1'b0, 0);
      checkOutput("signed max neg", 96'(bus.out_data_1[0 +: W]), 96'(24'hFFFFFD));

      planQ.delete();
      planQ.push_back(lane0Beat(-1, 0)); planQ.push_back(lane0Beat(-2, -3));
      applyStimulus(1, 1, 100, 1'b0, 0);
      checkOutput("signed max zero", 96'(bus.out_data_1[0 +: W]), 96'd0);

      planRandom(4, 2); applyStimulus(4, 2, 50, 1'b0, 0);
      planQ.delete();   applyStimulus(0, 3, 100, 1'b0, 0);
      planQ.delete();   applyStimulus(5, 0, 100, 1'b0, 0);
      planRandom(6, 3); applyStimulus(6, 3, 70, 1'b1, 0);

      planRandom(4, 2); applyStimulus(4, 2, 100, 1'b0, 5);
      planRandom(3, 2); applyStimulus(3, 2, 80, 1'b0, 0);

      for (int j = 0; j < 4; j++) begin
         int p, n;
         p = $urandom_range(1, 12);
         n = $urandom_range(1, 4);
         planRandom(p, n);
         applyStimulus(p, n, $urandom_range(40, 100), 1'b1, 0);
      end

      planRandom(LBD, 2); applyStimulus(LBD, 2, 85, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end
endmodule
